bcd_seg_display: RTL and testbench

BCD_SEG_DISPLAY -- requirements
Module: bcd_seg_display

---
 rtl/bcd_seg_display.sv | 87 ++++++++
 tb/tb_bcd_seg_display.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bcd_seg_display.sv
// Two-digit BCD result display: captures a BCD byte and time-multiplexes
// it onto a common-anode 7-segment pair. Option: LEADING_ZERO_BLANK_EN.
module bcd_seg_display #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] result_in,
   input  logic       load,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic          dig_q;
   logic [7:0]    hold_q;
   logic          valid_q;
   logic [3:0]    nib;
   logic [7:0]    an_d;
   logic [6:0]    seg_d;

   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   always_comb begin
      nib   = dig_q ? hold_q[7:4] : hold_q[3:0];
      an_d  = dig_q ? 8'hFD : 8'hFE;
      seg_d = decode(nib);
`ifdef LEADING_ZERO_BLANK_EN
      if (dig_q && hold_q[7:4] == 4'h0) begin
         an_d  = 8'hFF;
         seg_d = 7'h7F;
      end
`endif
      if (!valid_q) begin
         an_d  = 8'hFF;
         seg_d = 7'h7F;
      end
   end

   // Outputs are registered from the current scan state: one-cycle latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         dig_q   <= 1'b0;
         hold_q  <= 8'h00;
         valid_q <= 1'b0;
         an      <= 8'hFF;
         seg     <= 7'h7F;
         dp      <= 1'b1;
      end else begin
         if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            dig_q <= ~dig_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (load) begin
            hold_q  <= result_in;
            valid_q <= 1'b1;
         end
         an  <= an_d;
         seg <= seg_d;
         dp  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bcd_seg_display.sv
// Directed bench for bcd_seg_display with REFRESH_DIV=4.
// Define LEADING_ZERO_BLANK_EN for both bench and RTL to test the option.
module tb_bcd_seg_display;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] result_in;
   logic       load;
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp;

   int n_pass = 0;
   int n_tot  = 0;
   int k      = 0;

   always #5 clk = ~clk;

   bcd_seg_display #(.REFRESH_DIV(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .result_in(result_in),
      .load     (load),
      .an       (an),
      .seg      (seg),
      .dp       (dp)
   );

   function automatic logic [6:0] segtab(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      k++;
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [15:0] exp);
      logic [15:0] obs;
      obs = {an, seg, dp};
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s k=%0d an/seg/dp=%h expected %h", tag, k, obs, exp);
   endtask

   task automatic chk_blank(input string tag);
      chk(tag, {8'hFF, 7'h7F, 1'b1});
   endtask

   // Output after edge k reflects scan state after edge k-1.
   task automatic chk_disp(input string tag, input logic [7:0] v);
      int d;
      logic [15:0] e;
      d = ((k - 1) / 4) % 2;
      if (d == 0) e = {8'hFE, segtab(v[3:0]), 1'b1};
      else e = {8'hFD, segtab(v[7:4]), 1'b1};
`ifdef LEADING_ZERO_BLANK_EN
      if (d == 1 && v[7:4] == 4'h0) e = {8'hFF, 7'h7F, 1'b1};
`endif
      chk(tag, e);
   endtask

   task automatic load_val(input logic [7:0] v);
      result_in = v;
      load = 1'b1;
      tick();
      load = 1'b0;
      tick();
   endtask

   initial begin
      logic [7:0] seq [5];
      seq[0] = 8'h21; seq[1] = 8'h43; seq[2] = 8'h65;
      seq[3] = 8'h87; seq[4] = 8'h90;
      rst = 1'b1; load = 1'b0; result_in = 8'h00;
      @(negedge clk);
      tick(); tick();
      chk_blank("reset");
      rst = 1'b0; k = 0;
      for (int i = 0; i < 20; i++) begin tick(); chk_blank("idle"); end

      load_val(8'h17);
      for (int i = 0; i < 16; i++) begin chk_disp("h17", 8'h17); tick(); end

      load_val(8'h0A);
      for (int i = 0; i < 8; i++) begin chk_disp("h0A", 8'h0A); tick(); end
      load_val(8'h1A);
      for (int i = 0; i < 8; i++) begin chk_disp("h1A", 8'h1A); tick(); end
      load_val(8'h05);
      for (int i = 0; i < 8; i++) begin chk_disp("h05", 8'h05); tick(); end

      load_val(8'h12);
      result_in = 8'h99;
      for (int i = 0; i < 8; i++) begin chk_disp("hold12", 8'h12); tick(); end

      load = 1'b1;
      result_in = seq[0];
      tick();
      for (int i = 1; i < 5; i++) begin
         result_in = seq[i];
         tick();
         chk_disp("track", seq[i-1]);
      end
      tick();
      chk_disp("track_last", seq[4]);

      rst = 1'b1; result_in = 8'h34;
      tick();
      chk_blank("rst_over_load");
      rst = 1'b0; load = 1'b0; k = 0;
      for (int i = 0; i < 6; i++) begin tick(); chk_blank("post_rst"); end

      load_val(8'h48);
      while (k % 8 != 6) tick();
      chk_disp("pre_rst", 8'h48);
      rst = 1'b1;
      tick();
      chk_blank("mid_rst");
      rst = 1'b0; k = 0;
      for (int i = 0; i < 5; i++) begin tick(); chk_blank("blank_wait"); end

      rst = 1'b1;
      tick();
      rst = 1'b0; k = 0;
      load_val(8'h36);
      for (int i = 0; i < 12; i++) begin chk_disp("h36", 8'h36); tick(); end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout k=%0d", k);
      $fatal(1);
   end

endmodule
